// File: rtl/sprite_compositor.sv
// Purpose : N-channel sprite compositor (priority + transparency, CLUT lookup, per-frame collisions).
// Latency : 3 cycles from inputs to hsync/vsync/bright/RGB outputs; positions update 1 cycle after frame.
// Backpr. : none, it is a free-running pixel pipeline that accepts one pixel per clock.
// Ports   : clk/rst (sync, active-high); frame pulse; raw syncs + bright in; per-sprite drawing
//           flags and colour indices in; register write port (shadow X/Y/enable); CLUT write port;
//           active positions, collision flags and delay-aligned VGA sync/colour out.
module sprite_compositor #(
  parameter int                  N_SPR      = 4,
  parameter int                  CORDW      = 16,
  parameter int                  CIDXW      = 4,
  parameter int                  CHANW      = 4,
  parameter int                  OUT_W      = 8,
  parameter int                  TRANS_INDX = 15,
  parameter logic [3*CHANW-1:0]  BG_COLR    = 'h137
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic                        bright_in,
  input  logic [N_SPR-1:0]            spr_drawing,
  input  logic [N_SPR*CIDXW-1:0]      spr_pix,
  input  logic                        reg_we,
  input  logic [$clog2(N_SPR)+1:0]    reg_addr,
  input  logic [CORDW-1:0]            reg_wdata,
  input  logic                        clut_we,
  input  logic [CIDXW-1:0]            clut_addr,
  input  logic [3*CHANW-1:0]          clut_wdata,
  output logic [N_SPR*CORDW-1:0]      sprx,
  output logic [N_SPR*CORDW-1:0]      spry,
  output logic [N_SPR-1:0]            coll_status,
  output logic                        vga_hsync,
  output logic                        vga_vsync,
  output logic                        bright,
  output logic [OUT_W-1:0]            vga_r,
  output logic [OUT_W-1:0]            vga_g,
  output logic [OUT_W-1:0]            vga_b
);

  localparam int              AW    = $clog2(N_SPR) + 2;
  localparam logic [CIDXW-1:0] TRANS = CIDXW'(TRANS_INDX);

  // Shadow (CPU-written) and active (frame-latched) sprite registers
  logic [CORDW-1:0] shx_q [N_SPR];
  logic [CORDW-1:0] shy_q [N_SPR];
  logic [CORDW-1:0] acx_q [N_SPR];
  logic [CORDW-1:0] acy_q [N_SPR];
  logic [N_SPR-1:0] shen_q, acen_q;

  logic [3*CHANW-1:0] clut_q [2**CIDXW];

  logic [AW-1:0]      wr_sel;
  logic [N_SPR-1:0]   opq, hit;
  logic [4:0]         n_opq;
  logic [CIDXW-1:0]   s1_idx_d;
  logic [N_SPR-1:0]   coll_acc_q;

  logic [CIDXW-1:0]   s1_idx_q;
  logic               s1_any_q, s2_any_q;
  logic [2:0]         s1_sync_q, s2_sync_q;   // {hsync, vsync, bright}
  logic [3*CHANW-1:0] s2_rgb_q, col_d;

  function automatic logic [OUT_W-1:0] left_align(input logic [CHANW-1:0] c);
    return OUT_W'(c) << (OUT_W - CHANW);
  endfunction

  // Sprite index lives above the 2-bit field; indices >= N_SPR match no sprite below.
  assign wr_sel = reg_addr >> 2;

  for (genvar g = 0; g < N_SPR; g++) begin : g_pos
    assign sprx[g*CORDW +: CORDW] = acx_q[g];
    assign spry[g*CORDW +: CORDW] = acy_q[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SPR; i++) begin
        shx_q[i] <= '0;
        shy_q[i] <= '0;
        acx_q[i] <= '0;
        acy_q[i] <= '0;
      end
      shen_q <= '0;
      acen_q <= '0;
    end else begin
      if (reg_we) begin
        for (int i = 0; i < N_SPR; i++) begin
          if (wr_sel == AW'(i)) begin
            case (reg_addr[1:0])
              2'd0:    shx_q[i]  <= reg_wdata;
              2'd1:    shy_q[i]  <= reg_wdata;
              2'd2:    shen_q[i] <= reg_wdata[0];
              default: ;
            endcase
          end
        end
      end
      // Active takes the pre-write shadow, so a write coinciding with frame waits a frame.
      if (frame) begin
        for (int i = 0; i < N_SPR; i++) begin
          acx_q[i] <= shx_q[i];
          acy_q[i] <= shy_q[i];
        end
        acen_q <= shen_q;
      end
    end
  end

  // Opacity, lowest-index-wins priority and overlap count
  always_comb begin
    opq      = '0;
    n_opq    = '0;
    s1_idx_d = '0;
    for (int i = 0; i < N_SPR; i++) begin
      opq[i] = acen_q[i] & spr_drawing[i] & (spr_pix[i*CIDXW +: CIDXW] != TRANS);
      n_opq  = n_opq + 5'(opq[i]);
    end
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (opq[i]) s1_idx_d = spr_pix[i*CIDXW +: CIDXW];
    end
    hit = opq & {N_SPR{n_opq >= 5'd2}};
  end

  // CLUT: no reset, read-old-data on a same-cycle address collision
  always_ff @(posedge clk) begin
    if (clut_we && !rst) clut_q[clut_addr] <= clut_wdata;
  end

  always_comb begin
    col_d = s2_any_q ? s2_rgb_q : BG_COLR;
    if (!s2_sync_q[0]) col_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_idx_q    <= '0;
      s1_any_q    <= 1'b0;
      s1_sync_q   <= '0;
      s2_rgb_q    <= '0;
      s2_any_q    <= 1'b0;
      s2_sync_q   <= '0;
      vga_hsync   <= 1'b0;
      vga_vsync   <= 1'b0;
      bright      <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      coll_acc_q  <= '0;
      coll_status <= '0;
    end else begin
      s1_idx_q  <= s1_idx_d;
      s1_any_q  <= |opq;
      s1_sync_q <= {hsync_in, vsync_in, bright_in};
      s2_rgb_q  <= clut_q[s1_idx_q];
      s2_any_q  <= s1_any_q;
      s2_sync_q <= s1_sync_q;
      vga_hsync <= s2_sync_q[2];
      vga_vsync <= s2_sync_q[1];
      bright    <= s2_sync_q[0];
      vga_r     <= left_align(col_d[3*CHANW-1 -: CHANW]);
      vga_g     <= left_align(col_d[2*CHANW-1 -: CHANW]);
      vga_b     <= left_align(col_d[CHANW-1   -: CHANW]);
      // Frame-cycle hits belong to the frame that is starting.
      if (frame) begin
        coll_status <= coll_acc_q;
        coll_acc_q  <= hit;
      end else begin
        coll_acc_q  <= coll_acc_q | hit;
      end
    end
  end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised N-channel sprite compositor for the VGA path.
- Takes per-sprite drawing flags and colour indices from N_SPR sprite instances, plus raw sync/bright from vga_control.
- Owns double-buffered sprite position and enable registers, exported to the sprite instances, and a writable colour lookup table.
- Performs priority compositing with transparency, tracks per-sprite collisions per frame, and drives the delay-aligned VGA outputs.

Parameters:
N_SPR, 4, number of sprite channels (1..16)
CORDW, 16, signed coordinate width
CIDXW, 4, colour index width; CLUT depth 2**CIDXW
CHANW, 4, CLUT channel width; entry width 3*CHANW ordered {R,G,B}
OUT_W, 8, output channel width (>= CHANW)
TRANS_INDX, 15, transparent colour index
BG_COLR, 'h137, background colour {R,G,B}, 3*CHANW bits

Ports:
clk  in  1  pixel clock (25 MHz)
rst  in  1  synchronous active-high reset
frame  in  1  one-cycle pulse at start of frame
hsync_in  in  1  raw horizontal sync
vsync_in  in  1  raw vertical sync
bright_in  in  1  active-video flag
spr_drawing  in  N_SPR  per-sprite drawing flag; bit i = sprite i
spr_pix  in  N_SPR*CIDXW  per-sprite colour index; slice i at [i*CIDXW +: CIDXW]
reg_we  in  1  register write strobe
reg_addr  in  clog2(N_SPR)+2  {sprite index, field[1:0]}
reg_wdata  in  CORDW  register write data
clut_we  in  1  CLUT write strobe
clut_addr  in  CIDXW  CLUT write address
clut_wdata  in  3*CHANW  CLUT write data
sprx  out  N_SPR*CORDW  active X positions; slice i = sprite i
spry  out  N_SPR*CORDW  active Y positions
coll_status  out  N_SPR  per-sprite collision flags for the previous frame
vga_hsync  out  1  delayed sync
vga_vsync  out  1  delayed sync
bright  out  1  delayed bright
vga_r, vga_g, vga_b  out  OUT_W each  pixel colour

Behaviour:
- Reset (synchronous, highest priority over all other events):
  - All outputs 0, including syncs.
  - Shadow and active X/Y = 0; enables = 0; coll_acc = 0; pipeline registers = 0.
  - CLUT contents are not reset; power-up content is 0.
- Register fields:
  - field 0 = X, field 1 = Y: full CORDW, signed.
  - field 2 = ctrl: bit0 = enable; other bits ignored.
  - field 3: write ignored.
  - Sprite index >= N_SPR: write ignored.
- Double buffering:
  - Writes land in shadow registers only.
  - On a frame cycle, active <= shadow for every sprite.
  - A write in the same cycle as frame updates shadow only; it takes effect at the next frame.
- Opaque term: opq[i] = enable_active[i] & spr_drawing[i] & (pix_i != TRANS_INDX).
- Priority: the lowest index with opq set wins.
- Pipeline (latency 3 cycles from inputs to all VGA outputs):
  - S1: register winner index, any_opq, hsync/vsync/bright.
  - S2: synchronous CLUT read of winner index; delay any_opq and syncs.
  - S3: colour = any_opq ? CLUT entry : BG_COLR. If bright is 0 at S3, colour is forced to 0. Each channel is left-aligned in OUT_W, low bits zero. Register all outputs.
  - hsync/vsync/bright outputs equal their inputs delayed exactly 3 cycles.
- CLUT write:
  - Write-first is not required.
  - A read of the address written in the same cycle returns the old data.
  - The new value is visible from the next cycle.
- Collision:
  - hit[i] = opq[i] & (popcount(opq) >= 2).
  - Each cycle, coll_acc |= hit.
  - On frame: coll_status <= coll_acc; coll_acc <= hit (the frame cycle's hits count toward the new frame).
  - Disabled sprites never collide.
- N_SPR = 1: coll_status is constantly 0 after reset; priority logic degenerates to a pass-through.

Test Plan:
- Reset, then write sprite 0 X=100, Y=25, enable=1 with no frame pulse -> sprx/spry slice 0 stay 0 until the next frame; one cycle after frame, sprx[0]=100, spry[0]=25.
- CLUT[3]=12'hF80; sprite 0 enabled, drawing, pix=3, bright=1 -> 3 cycles later vga_r=8'hF0, vga_g=8'h80, vga_b=8'h00; nothing drawing -> 8'h10, 8'h30, 8'h70.
- Sprites 0 and 1 both opaque (pix 2 and 5) -> CLUT[2] is shown. Sprite 0 pix=TRANS_INDX -> CLUT[5] is shown. Sprite 0 disabled -> CLUT[5] is shown.
- Sprites 1 and 2 overlap opaque for one cycle mid-frame, sprite 0 is alone -> after the next frame, coll_status=4'b0110; after a clean frame, it returns to 0.
- hsync_in toggled with bright_in=0 and sprite opaque -> vga_hsync follows 3 cycles later; RGB=0.
- Assert rst mid-frame with sprites enabled -> the next cycle, all outputs, positions and coll_status = 0; the CLUT retains its values.
